irda_tx_ctrl: RTL and testbench

Transmit sequencer for the IrDA SIR transmit path. Accepts one byte per valid/ready handshake, builds a 12-bit UART-style frame, drives `load`/`shift` of the 12-bit transmit shift register at baud rate, and encodes its `lastbit` output as IrDA return-to-zero pulses. It sits between the host byte interface and the shift register, and owns all baud timing for the transmitter.

---
 rtl/irda_tx_ctrl.sv | 132 +++++++++++++
 tb/tb_irda_tx_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irda_tx_ctrl.sv
// irda_tx_ctrl: IrDA SIR transmit sequencer.
// Accepts a byte on a valid/ready handshake and frames it as start + 8 data
// (LSB first) + stop, padded with ones to 12 bits. It drives load/shift
// strobes for the external 12-bit shift register at baud rate. It turns the
// line bit (lastbit) into return-to-zero IR pulses.
// Optional feature: define IRDA_TX_PARITY_EN to insert an even-parity bit
// ahead of the stop bit (11-bit frame instead of 10).

module irda_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PULSE_CLKS   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        lastbit,
  output logic        sr_load,
  output logic        sr_shift,
  output logic [11:0] sr_dat,
  output logic        ir_tx,
  output logic        busy,
  output logic        tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef IRDA_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam logic [BW-1:0] LAST_BAUD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] PULSE_LIM = BW'(PULSE_CLKS);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [3:0]     bit_q, bit_d;
  logic [11:0]    frame_q, frame_d;
  logic           done_q, done_d;

  // Bit 0 goes out first; unused upper positions are ones so the line
  // idles high once the frame has shifted out.
  function automatic logic [11:0] build_frame(input logic [7:0] data);
`ifdef IRDA_TX_PARITY_EN
    return {2'b11, ^data, data, 1'b0};
`else
    return {3'b111, data, 1'b0};
`endif
  endfunction

  // State and counter registers with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      frame_q <= 12'hFFF;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counter and strobe decode.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    done_d   = 1'b0;
    tx_ready = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        baud_d   = '0;
        bit_d    = '0;
        if (tx_valid) begin
          frame_d = build_frame(tx_data);
          state_d = LOAD;
        end
      end
      LOAD: begin
        sr_load = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (baud_q == LAST_BAUD) begin
          sr_shift = 1'b1;
          baud_d   = '0;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // IR pulse covers the first PULSE_CLKS clocks of every zero bit; decoded
  // from registered state and the shift register output only.
  assign ir_tx   = (state_q == SEND) & ~lastbit & (baud_q < PULSE_LIM);
  assign busy    = (state_q != IDLE);
  assign sr_dat  = frame_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_irda_tx_ctrl.sv
// Testbench for irda_tx_ctrl: external shift register, a cycle-indexed
// behavioural model checked every cycle, a table of known frames, hand
// sequences for reset / back-to-back / busy corner cases, and random traffic.

module tb_irda_tx_ctrl;

  localparam int C = 16;
  localparam int P = 3;
`ifdef IRDA_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WAIT_MAX = 400;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;
    int          pulses;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, lastbit, sr_load, sr_shift, ir_tx, busy, tx_done;
  logic [11:0] sr_dat;
  logic [11:0] sr_q = 12'hFFF;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irda_tx_ctrl #(.CLKS_PER_BIT(C), .PULSE_CLKS(P)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .lastbit(lastbit), .sr_load(sr_load),
    .sr_shift(sr_shift), .sr_dat(sr_dat), .ir_tx(ir_tx), .busy(busy),
    .tx_done(tx_done)
  );

  // External 12-bit shift register sharing the reset net; shifts in ones.
  always @(posedge clk) begin
    if (reset)         sr_q <= 12'hFFF;
    else if (sr_load)  sr_q <= sr_dat;
    else if (sr_shift) sr_q <= {1'b1, sr_q[11:1]};
  end
  assign lastbit = sr_q[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] frame_of(input logic [7:0] d);
    logic [11:0] f;
    f = 12'hFFF;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef IRDA_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Model: m_k counts cycles since the accepting edge. Cycle 0 is the load
  // cycle, cycles 1..FB*C carry frame bit (k-1)/C, the next cycle is done.
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  int          m_k = 0;
  logic [11:0] m_frame = 12'hFFF;
  logic [11:0] m_sr_dat = 12'hFFF;
  int          m_accepts = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
      m_sr_dat = 12'hFFF;
    end else if (m_active) begin
      m_done = 1'b0;
      if (m_k == FB * C) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_k++;
      end
    end else begin
      m_done = 1'b0;
      if (tx_valid) begin
        m_active = 1'b1;
        m_k      = 0;
        m_frame  = frame_of(tx_data);
        m_sr_dat = m_frame;
        m_accepts++;
      end
    end
  end

  // Per-cycle comparison of all outputs and the line against the model.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      logic [6:0] exp_v, act_v;
      int j;
      bit in_send;
      logic bitv;
      in_send = m_active && (m_k >= 1);
      j       = m_k - 1;
      bitv    = in_send ? m_frame[j / C] : 1'b1;
      exp_v = {m_active, !m_active, m_active && (m_k == 0),
               in_send && (j % C == C - 1), m_done,
               in_send && !bitv && (j % C < P), bitv};
      act_v = {busy, tx_ready, sr_load, sr_shift, tx_done, ir_tx, lastbit};
      check("cycle{busy,rdy,load,shift,done,ir,line}", {25'd0, act_v}, {25'd0, exp_v});
      check("sr_dat", {20'd0, sr_dat}, {20'd0, m_sr_dat});
    end
  end

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (sr_load) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FB * C + WAIT_MAX; i++) begin
      @(negedge clk);
      if (tx_done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Send one byte and measure what the frame looked like from outside.
  task automatic run_frame(input logic [7:0] d, output logic [11:0] frame_seen,
                           output int pulses, output int shifts, output int latency);
    bit ok, done, prev;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    wait_load(ok);
    check("accept_timeout", {31'd0, ok}, 32'd1);
    frame_seen = sr_dat;
    tx_valid = 1'b0;
    tx_data  = ~d;
    pulses = 0; shifts = 0; latency = 0; prev = 1'b0; done = 1'b0;
    for (int i = 0; i < FB * C + 20 && !done; i++) begin
      @(negedge clk);
      if (tx_done) begin
        done = 1'b1;
      end else begin
        latency++;
        if (ir_tx && !prev) pulses++;
        prev = ir_tx;
        if (sr_shift) shifts++;
      end
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    vec_t        vec [5];
    logic [11:0] f;
    int          p, s, l, cnt, base;
    bit          ok;

`ifdef IRDA_TX_PARITY_EN
    vec[0] = '{8'h55, 12'hCAA, 6};
    vec[1] = '{8'h00, 12'hC00, 10};
    vec[2] = '{8'hFF, 12'hDFE, 2};
    vec[3] = '{8'hA3, 12'hD46, 6};
    vec[4] = '{8'h07, 12'hE0E, 6};
`else
    vec[0] = '{8'h55, 12'hEAA, 5};
    vec[1] = '{8'h00, 12'hE00, 9};
    vec[2] = '{8'hFF, 12'hFFE, 1};
    vec[3] = '{8'hA3, 12'hF46, 5};
    vec[4] = '{8'h07, 12'hE0E, 6};
`endif

    // Reset values.
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_sr_load",  {31'd0, sr_load},  32'd0);
    check("rst_sr_shift", {31'd0, sr_shift}, 32'd0);
    check("rst_sr_dat",   {20'd0, sr_dat},   32'hFFF);
    check("rst_ir_tx",    {31'd0, ir_tx},    32'd0);
    check("rst_tx_done",  {31'd0, tx_done},  32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle for 50 cycles: no strobes, no IR, always ready.
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sr_load || sr_shift || ir_tx || !tx_ready) cnt++;
    end
    check("idle_activity", cnt, 0);

    // Table of known frames.
    for (int i = 0; i < 5; i++) begin
      run_frame(vec[i].data, f, p, s, l);
      check("frame_word",   {20'd0, f}, {20'd0, vec[i].frame});
      check("ir_pulses",    p, vec[i].pulses);
      check("shift_count",  s, FB);
      check("done_latency", l, FB * C);
    end

    // Back-to-back: valid held, second byte accepted in the done cycle.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    wait_load(ok);
    check("b2b_accept1", {31'd0, ok}, 32'd1);
    tx_data = 8'hFF;
    wait_done(ok);
    check("b2b_done1", {31'd0, ok}, 32'd1);
    check("b2b_ready_at_done", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    check("b2b_load2", {31'd0, sr_load}, 32'd1);
    check("b2b_frame2", {20'd0, sr_dat}, {20'd0, frame_of(8'hFF)});
    tx_valid = 1'b0;
    wait_done(ok);
    check("b2b_done2", {31'd0, ok}, 32'd1);

    // Reset during bit 4 of 0xA3: frame abandoned, no done pulse.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hA3;
    wait_load(ok);
    check("rstmid_accept", {31'd0, ok}, 32'd1);
    tx_valid = 1'b0;
    repeat (4 * C + 6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_busy",   {31'd0, busy},    32'd0);
    check("rstmid_ir_tx",  {31'd0, ir_tx},   32'd0);
    check("rstmid_line",   {31'd0, lastbit}, 32'd1);
    check("rstmid_sr_dat", {20'd0, sr_dat},  32'hFFF);
    cnt = 0;
    for (int i = 0; i < FB * C + 40; i++) begin
      @(negedge clk);
      if (tx_done) cnt++;
    end
    check("rstmid_no_done", cnt, 0);

    // Reset and valid in the same cycle: reset wins.
    @(negedge clk);
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    @(negedge clk);
    reset    = 1'b0;
    tx_valid = 1'b0;
    check("rstval_busy",    {31'd0, busy},    32'd0);
    check("rstval_sr_load", {31'd0, sr_load}, 32'd0);
    @(negedge clk);
    check("rstval_no_load", {31'd0, sr_load}, 32'd0);

    // Valid with a different byte while busy: held off until ready.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    wait_load(ok);
    check("busy_accept1", {31'd0, ok}, 32'd1);
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < FB * C + WAIT_MAX && !ok; i++) begin
      @(negedge clk);
      if (sr_load) cnt++;
      if (tx_done) ok = 1'b1;
    end
    check("busy_done1", {31'd0, ok}, 32'd1);
    check("busy_no_early_load", cnt, 0);
    @(negedge clk);
    check("busy_load2", {31'd0, sr_load}, 32'd1);
    check("busy_frame2", {20'd0, sr_dat}, {20'd0, frame_of(8'hC3)});
    tx_valid = 1'b0;
    wait_done(ok);
    check("busy_done2", {31'd0, ok}, 32'd1);

    // Random traffic: data changes every cycle, sporadic valid and reset.
    base = m_accepts;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      tx_data  = 8'($urandom);
      tx_valid = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    reset    = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < FB * C + WAIT_MAX && !ok; i++) begin
      @(negedge clk);
      if (!m_active) ok = 1'b1;
    end
    check("random_drain", {31'd0, ok}, 32'd1);
    check("random_accepts", {31'd0, (m_accepts - base) >= 15}, 32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
